// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: turns single unit commands (word-addressed) into
// AXI4-Lite read or write transactions, one outstanding at a time, and
// returns the captured response on the unit response channel.
module axi_lite_master #(
  parameter int DATA_WIDTH      = 32,
  parameter int MEMORY_MAP_SIZE = 65536,
  parameter int STROBE_WIDTH    = DATA_WIDTH / 8,
  parameter int AXI_ADDR_WIDTH  = $clog2(MEMORY_MAP_SIZE * 4),
  parameter int SLV_ADDR_WIDTH  = AXI_ADDR_WIDTH - $clog2(STROBE_WIDTH)
) (
  input  logic                      m_axi_aclk,
  input  logic                      m_axi_areset,
  // AXI write address channel
  output logic                      m_axi_awvalid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  input  logic                      m_axi_awready,
  // AXI write data channel
  output logic                      m_axi_wvalid,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [STROBE_WIDTH-1:0]   m_axi_wstrb,
  input  logic                      m_axi_wready,
  // AXI write response channel
  input  logic                      m_axi_bvalid,
  input  logic [1:0]                m_axi_bresp,
  output logic                      m_axi_bready,
  // AXI read address channel
  output logic                      m_axi_arvalid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  input  logic                      m_axi_arready,
  // AXI read data channel
  input  logic                      m_axi_rvalid,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  output logic                      m_axi_rready,
  // Unit command channel
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [SLV_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [STROBE_WIDTH-1:0]   cmd_wstrb,
  // Unit response channel
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [1:0]                rsp_resp,
  output logic [DATA_WIDTH-1:0]     rsp_rdata
);

  localparam int ADDR_LSB = $clog2(STROBE_WIDTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                    r_state,     w_state;
  logic                      r_awvalid,   w_awvalid;
  logic [AXI_ADDR_WIDTH-1:0] r_awaddr,    w_awaddr;
  logic                      r_wvalid,    w_wvalid;
  logic [DATA_WIDTH-1:0]     r_wdata,     w_wdata;
  logic [STROBE_WIDTH-1:0]   r_wstrb,     w_wstrb;
  logic                      r_bready,    w_bready;
  logic                      r_arvalid,   w_arvalid;
  logic [AXI_ADDR_WIDTH-1:0] r_araddr,    w_araddr;
  logic                      r_rready,    w_rready;
  logic                      r_cmd_ready, w_cmd_ready;
  logic                      r_rsp_valid, w_rsp_valid;
  logic                      r_rsp_write, w_rsp_write;
  logic [1:0]                r_rsp_resp,  w_rsp_resp;
  logic [DATA_WIDTH-1:0]     r_rsp_rdata, w_rsp_rdata;

  // Word address from the unit side becomes a lane-aligned byte address.
  logic [AXI_ADDR_WIDTH-1:0] w_byte_addr;
  assign w_byte_addr = AXI_ADDR_WIDTH'(cmd_addr) << ADDR_LSB;

  // A write channel is finished once its valid is low or handshaking now.
  logic w_aw_done;
  logic w_w_done;
  assign w_aw_done = !r_awvalid || m_axi_awready;
  assign w_w_done  = !r_wvalid  || m_axi_wready;

  // State register and all registered outputs.
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      r_state     <= IDLE;
      r_awvalid   <= 1'b0;
      r_awaddr    <= '0;
      r_wvalid    <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_rready    <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_resp  <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state;
      r_awvalid   <= w_awvalid;
      r_awaddr    <= w_awaddr;
      r_wvalid    <= w_wvalid;
      r_wdata     <= w_wdata;
      r_wstrb     <= w_wstrb;
      r_bready    <= w_bready;
      r_arvalid   <= w_arvalid;
      r_araddr    <= w_araddr;
      r_rready    <= w_rready;
      r_cmd_ready <= w_cmd_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_write <= w_rsp_write;
      r_rsp_resp  <= w_rsp_resp;
      r_rsp_rdata <= w_rsp_rdata;
    end
  end

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    w_state     = r_state;
    w_awvalid   = r_awvalid;
    w_awaddr    = r_awaddr;
    w_wvalid    = r_wvalid;
    w_wdata     = r_wdata;
    w_wstrb     = r_wstrb;
    w_bready    = r_bready;
    w_arvalid   = r_arvalid;
    w_araddr    = r_araddr;
    w_rready    = r_rready;
    w_cmd_ready = r_cmd_ready;
    w_rsp_valid = r_rsp_valid;
    w_rsp_write = r_rsp_write;
    w_rsp_resp  = r_rsp_resp;
    w_rsp_rdata = r_rsp_rdata;

    case (r_state)
      IDLE: begin
        w_cmd_ready = 1'b1;
        if (cmd_valid && r_cmd_ready) begin
          w_cmd_ready = 1'b0;
          if (cmd_write) begin
            w_awaddr  = w_byte_addr;
            w_wdata   = cmd_wdata;
            w_wstrb   = cmd_wstrb;
            w_awvalid = 1'b1;
            w_wvalid  = 1'b1;
            w_state   = WR_REQ;
          end else begin
            w_araddr  = w_byte_addr;
            w_arvalid = 1'b1;
            w_state   = RD_REQ;
          end
        end
      end

      WR_REQ: begin
        // AW and W complete independently; B is opened only after both.
        if (r_awvalid && m_axi_awready) w_awvalid = 1'b0;
        if (r_wvalid && m_axi_wready)   w_wvalid  = 1'b0;
        if (w_aw_done && w_w_done) begin
          w_bready = 1'b1;
          w_state  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (m_axi_bvalid && r_bready) begin
          w_bready    = 1'b0;
          w_rsp_resp  = m_axi_bresp;
          w_rsp_write = 1'b1;
          w_rsp_rdata = '0;
          w_rsp_valid = 1'b1;
          w_state     = RSP;
        end
      end

      RD_REQ: begin
        if (r_arvalid && m_axi_arready) begin
          w_arvalid = 1'b0;
          w_rready  = 1'b1;
          w_state   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (m_axi_rvalid && r_rready) begin
          w_rready    = 1'b0;
          w_rsp_rdata = m_axi_rdata;
          w_rsp_resp  = m_axi_rresp;
          w_rsp_write = 1'b0;
          w_rsp_valid = 1'b1;
          w_state     = RSP;
        end
      end

      RSP: begin
        if (r_rsp_valid && rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_cmd_ready = 1'b1;
          w_state     = IDLE;
        end
      end

      default: begin
        w_state     = IDLE;
        w_awvalid   = 1'b0;
        w_wvalid    = 1'b0;
        w_bready    = 1'b0;
        w_arvalid   = 1'b0;
        w_rready    = 1'b0;
        w_rsp_valid = 1'b0;
        w_cmd_ready = 1'b1;
      end
    endcase
  end

  assign m_axi_awvalid = r_awvalid;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_bready  = r_bready;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = r_rready;
  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_write     = r_rsp_write;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_rdata     = r_rsp_rdata;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: the bench plays the AXI slave and the
// unit-side controller cycle by cycle and checks hand-computed values.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [17:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_lite_master #(.DATA_WIDTH(32), .MEMORY_MAP_SIZE(65536)) dut (
    .m_axi_aclk(clk),        .m_axi_areset(rst),
    .m_axi_awvalid(awvalid), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_awready(awready),
    .m_axi_wvalid(wvalid),   .m_axi_wdata(wdata),   .m_axi_wstrb(wstrb),
    .m_axi_wready(wready),
    .m_axi_bvalid(bvalid),   .m_axi_bresp(bresp),   .m_axi_bready(bready),
    .m_axi_arvalid(arvalid), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_arready(arready),
    .m_axi_rvalid(rvalid),   .m_axi_rdata(rdata),   .m_axi_rresp(rresp),
    .m_axi_rready(rready),
    .cmd_valid(cmd_valid),   .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),     .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid),   .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_resp(rsp_resp),     .rsp_rdata(rsp_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_prot", {awprot, arprot}, 0);
    rst = 1'b0;
    tick();

    // Zero-wait write: addr 0x10 -> byte 0x40
    awready = 1'b1; wready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0010;
    cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
    tick();
    cmd_valid = 1'b0;
    chk("w1_cmd_ready", cmd_ready, 0);
    chk("w1_valids", {awvalid, wvalid}, 2'b11);
    chk("w1_awaddr", awaddr, 18'h00040);
    chk("w1_wdata", wdata, 32'hDEADBEEF);
    chk("w1_wstrb", wstrb, 4'hF);
    tick();
    chk("w1_valids_drop", {awvalid, wvalid}, 2'b00);
    chk("w1_bready", bready, 1);
    chk("w1_rsp_early", rsp_valid, 0);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    chk("w1_bready_drop", bready, 0);
    chk("w1_rsp_valid", rsp_valid, 1);
    chk("w1_rsp_write", rsp_write, 1);
    chk("w1_rsp_resp", rsp_resp, 2'b00);
    chk("w1_rsp_rdata", rsp_rdata, 0);
    tick();
    chk("w1_rsp_done", rsp_valid, 0);
    chk("w1_cmd_ready_back", cmd_ready, 1);

    // Zero-wait read of the same word
    arready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0010;
    tick();
    cmd_valid = 1'b0;
    chk("r1_arvalid", arvalid, 1);
    chk("r1_araddr", araddr, 18'h00040);
    chk("r1_no_write", {awvalid, wvalid}, 2'b00);
    tick();
    chk("r1_arvalid_drop", arvalid, 0);
    chk("r1_rready", rready, 1);
    rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b00;
    tick();
    rvalid = 1'b0;
    chk("r1_rready_drop", rready, 0);
    chk("r1_rsp_valid", rsp_valid, 1);
    chk("r1_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("r1_rsp_write", rsp_write, 0);
    chk("r1_rsp_resp", rsp_resp, 2'b00);
    tick();
    chk("r1_idle", cmd_ready, 1);

    // Write with awready low 5 cycles, wready immediate, SLVERR response
    awready = 1'b0; wready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0123;
    cmd_wdata = 32'h12345678; cmd_wstrb = 4'h5;
    tick();
    cmd_valid = 1'b0;
    chk("w2_valids", {awvalid, wvalid}, 2'b11);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("w2_wvalid_low", wvalid, 0);
      chk("w2_awvalid_hold", awvalid, 1);
      chk("w2_awaddr_stable", awaddr, 18'h0048C);
      chk("w2_bready_wait", bready, 0);
    end
    awready = 1'b1;
    tick();
    chk("w2_awvalid_drop", awvalid, 0);
    chk("w2_bready", bready, 1);
    bvalid = 1'b1; bresp = 2'b10;
    tick();
    bvalid = 1'b0;
    chk("w2_rsp_valid", rsp_valid, 1);
    chk("w2_rsp_resp", rsp_resp, 2'b10);
    chk("w2_rsp_write", rsp_write, 1);
    tick();
    chk("w2_idle", cmd_ready, 1);

    // Read to top word, DECERR with rvalid delayed 3 cycles; rsp_ready held low
    arready = 1'b1; rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'hFFFF;
    tick();
    cmd_valid = 1'b0;
    chk("r2_araddr", araddr, 18'h3FFFC);
    tick();
    chk("r2_rready", rready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r2_rready_wait", rready, 1);
      chk("r2_rsp_wait", rsp_valid, 0);
    end
    rvalid = 1'b1; rresp = 2'b11; rdata = 32'h0;
    tick();
    rvalid = 1'b0;
    chk("r2_rsp_valid", rsp_valid, 1);
    chk("r2_rsp_resp", rsp_resp, 2'b11);
    chk("r2_rsp_write", rsp_write, 0);

    // Backpressured response with a new command pending
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0005;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_resp", rsp_resp, 2'b11);
      chk("bp_rsp_rdata", rsp_rdata, 0);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_axi_quiet", {awvalid, wvalid, arvalid, bready, rready}, 0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_rsp_done", rsp_valid, 0);
    chk("bp_cmd_ready_back", cmd_ready, 1);
    chk("bp_not_yet", arvalid, 0);
    tick();
    cmd_valid = 1'b0;
    chk("bp_accepted", cmd_ready, 0);
    chk("bp_arvalid", arvalid, 1);
    chk("bp_araddr", araddr, 18'h00014);
    tick();
    rvalid = 1'b1; rdata = 32'h0000A5A5; rresp = 2'b00;
    tick();
    rvalid = 1'b0;
    chk("bp_rsp_rdata2", rsp_rdata, 32'h0000A5A5);
    tick();

    // Reset in the middle of WR_REQ
    awready = 1'b0; wready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0002;
    cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF;
    tick();
    cmd_valid = 1'b0;
    chk("ar_valids_before", {awvalid, wvalid}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("ar_async_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("ar_async_cmd_ready", cmd_ready, 1);
    tick();
    rst = 1'b0;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    tick(); tick();
    chk("ar_after_cmd_ready", cmd_ready, 1);
    chk("ar_after_rsp", rsp_valid, 0);
    chk("ar_after_quiet", {awvalid, wvalid, bready}, 0);
    bvalid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- AXI4-Lite initiator: converts a simple single-command/single-response unit interface into AXI4-Lite read and write transactions.
- Sits between internal controllers (sequencers, debug bridges, test drivers) and any AXI4-Lite slave port in the design.
- One transaction outstanding at a time.
- Word-addressed on the unit side, byte-addressed on the AXI side.

Parameters:
- DATA_WIDTH, 32, AXI data width in bits; multiple of 8.
- MEMORY_MAP_SIZE, 65536, number of addressable words.
- STROBE_WIDTH, DATA_WIDTH/8, byte lanes.
- AXI_ADDR_WIDTH, $clog2(MEMORY_MAP_SIZE*4), AXI byte-address width.
- SLV_ADDR_WIDTH, AXI_ADDR_WIDTH-$clog2(STROBE_WIDTH), unit word-address width.

Ports:
- m_axi_aclk  in  1  clock; all logic on rising edge.
- m_axi_areset  in  1  asynchronous, active-high reset.
- m_axi_awvalid  out  1  write address valid.
- m_axi_awaddr  out  AXI_ADDR_WIDTH  write byte address.
- m_axi_awprot  out  3  constant 3'b000.
- m_axi_awready  in  1  write address ready.
- m_axi_wvalid  out  1  write data valid.
- m_axi_wdata  out  DATA_WIDTH  write data.
- m_axi_wstrb  out  STROBE_WIDTH  write byte strobes.
- m_axi_wready  in  1  write data ready.
- m_axi_bvalid  in  1  write response valid.
- m_axi_bresp  in  2  write response code.
- m_axi_bready  out  1  write response ready.
- m_axi_arvalid  out  1  read address valid.
- m_axi_araddr  out  AXI_ADDR_WIDTH  read byte address.
- m_axi_arprot  out  3  constant 3'b000.
- m_axi_arready  in  1  read address ready.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rdata  in  DATA_WIDTH  read data.
- m_axi_rresp  in  2  read response code.
- m_axi_rready  out  1  read data ready.
- cmd_valid  in  1  unit command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  SLV_ADDR_WIDTH  word address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  STROBE_WIDTH  byte enables for writes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  unit consumes response.
- rsp_write  out  1  response belongs to a write.
- rsp_resp  out  2  captured bresp/rresp.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs 0 except cmd_ready=1; state=IDLE.
  - Reset asserted mid-transaction abandons it immediately; no response is produced.
- All outputs are registered.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: cmd_ready<=0; capture cmd_write.
  - Write: awaddr/araddr <= {cmd_addr, $clog2(STROBE_WIDTH) zeros}; wdata, wstrb captured; awvalid<=1, wvalid<=1 -> WR_REQ.
  - Read: same address formation; arvalid<=1 -> RD_REQ.
  - AXI valids therefore rise the cycle after acceptance.
- WR_REQ:
  - awvalid drops the cycle after awvalid&&awready; wvalid drops the cycle after wvalid&&wready; the two are independent, in either order or the same cycle.
  - Address, data and strobe stay stable while the corresponding valid is high.
  - When both handshakes are done: bready<=1 -> WR_RESP.
  - Valids never deassert before their handshake.
- WR_RESP: on bvalid&&bready: bready<=0; rsp_resp<=bresp; rsp_write<=1; rsp_rdata<=0; rsp_valid<=1 -> RSP.
- RD_REQ: on arvalid&&arready: arvalid<=0; rready<=1 -> RD_DATA.
- RD_DATA: on rvalid&&rready: rready<=0; rsp_rdata<=rdata; rsp_resp<=rresp; rsp_write<=0; rsp_valid<=1 -> RSP.
- RSP:
  - rsp_* held stable until rsp_valid&&rsp_ready.
  - On that handshake: rsp_valid<=0; cmd_ready<=1 -> IDLE.
  - Next command can be accepted the following cycle.
- Best-case latency with zero-wait slave and rsp_ready=1:
  - Write: accept at T; AW/W handshake at T+1; B handshake at T+2; rsp_valid at T+3.
  - Read: accept at T; AR at T+1; R at T+2; rsp_valid at T+3.
- Never issues read and write concurrently.
- bready/rready are low outside WR_RESP/RD_DATA.
- Non-OKAY responses (SLVERR 2'b10, DECERR 2'b11) are passed through unmodified; no retry.
- Unexpected bvalid/rvalid outside the matching state is ignored (ready low).
- Unreachable state -> IDLE with all valids/readies cleared.

Test Plan:
- Write cmd_addr=0x0010, wdata=0xDEADBEEF, wstrb=4'hF to a zero-wait slave -> awaddr=0x0040, awvalid/wvalid high exactly one cycle, rsp_valid at T+3, rsp_write=1, rsp_resp=2'b00.
- Read cmd_addr=0x0010 after that write, slave returns 0xDEADBEEF -> araddr=0x0040, rsp_rdata=0xDEADBEEF, rsp_write=0, rsp_resp=0.
- Write where awready is held low 5 cycles and wready is immediate -> wvalid drops after 1 cycle, awvalid held with awaddr stable for 6 cycles, bready rises only after the AW handshake.
- Read to an unmapped address with slave returning DECERR and rvalid delayed 3 cycles -> rsp_resp=2'b11; rready high throughout the wait.
- rsp_ready held low 4 cycles with a new cmd_valid pending -> rsp_* stable, cmd_ready=0, no AXI activity; command accepted the cycle after the rsp handshake.
- m_axi_areset asserted mid-WR_REQ (awvalid=1) -> all valids/readies 0 asynchronously, cmd_ready=1 after release, no rsp_valid.
